// File: rtl/sprite_index_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_index_writer
//  Description : Streams a rectangle of 24-bit RGB pixels, reverse-maps each
//                pixel through a programmable palette to a colour index and
//                issues one write per visible pixel into a row-major index
//                frame memory (address = y*FB_WIDTH + x).
//  Ports       : Clk, Reset           - clock, synchronous active-high reset
//                start,x0,y0,spr_w,spr_h - rectangle request and geometry
//                pal_we,pal_idx,pal_color - palette programming port
//                pix_valid,pix_data,pix_ready - source pixel handshake
//                wr_en,wr_address,wr_index - frame memory write port
//                busy, done, miss_count - status
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_index_writer #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W    = 19,
    parameter int IDX_W     = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
    input  logic [9:0]        spr_w,
    input  logic [9:0]        spr_h,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_idx,
    input  logic [23:0]       pal_color,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [IDX_W-1:0]  wr_index,
    output logic              busy,
    output logic              done,
    output logic [15:0]       miss_count
);

    localparam int c_PAL_DEPTH = 2**IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [23:0]         r_pal [c_PAL_DEPTH];
    logic [9:0]          r_x0;
    logic [9:0]          r_y0;
    logic [9:0]          r_w;
    logic [9:0]          r_h;
    logic [9:0]          r_col;
    logic [9:0]          r_row;
    logic [15:0]         r_miss;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [IDX_W-1:0]    r_wr_idx;

    logic                w_accept;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [10:0]         w_abs_x;
    logic [10:0]         w_abs_y;
    logic                w_in_frame;
    logic [ADDR_W-1:0]   w_addr;

    assign w_last_col = (r_col == r_w - 10'd1);
    assign w_last_row = (r_row == r_h - 10'd1);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pix_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (spr_w == 10'd0 || spr_h == 10'd0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                pix_ready = 1'b1;
                w_accept  = pix_valid;
                if (pix_valid && w_last_col && w_last_row) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Palette reverse lookup. Scanning from the top down lets the lowest
    // matching entry overwrite any higher one, so the lowest index wins.
    // The registered palette is used, so a same-cycle write is not yet seen.
    // ------------------------------------------------------------------------
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = c_PAL_DEPTH - 1; i >= 0; i--) begin
            if (r_pal[i] == pix_data) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // Absolute position at 11 bits so x0+col can never wrap back on-screen.
    assign w_abs_x    = {1'b0, r_x0} + {1'b0, r_col};
    assign w_abs_y    = {1'b0, r_y0} + {1'b0, r_row};
    assign w_in_frame = (w_abs_x < 11'(FB_WIDTH)) && (w_abs_y < 11'(FB_HEIGHT));
    assign w_addr     = ADDR_W'(w_abs_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(w_abs_x);

    // ------------------------------------------------------------------------
    // Palette storage
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < c_PAL_DEPTH; i++) begin
                r_pal[i] <= 24'h000000;
            end
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_color;
        end
    end

    // ------------------------------------------------------------------------
    // Rectangle walker, miss counter and registered write port
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x0      <= '0;
            r_y0      <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_miss    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_idx  <= '0;
        end else begin
            r_wr_en <= 1'b0;

            if (r_state == S_IDLE && start) begin
                r_x0   <= x0;
                r_y0   <= y0;
                r_w    <= spr_w;
                r_h    <= spr_h;
                r_col  <= '0;
                r_row  <= '0;
                r_miss <= '0;
            end

            if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end

                // Off-frame pixels are silently consumed and are not misses.
                if (w_in_frame) begin
                    if (w_hit) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_addr;
                        r_wr_idx  <= w_hit_idx;
                    end else if (r_miss != 16'hFFFF) begin
                        r_miss <= r_miss + 16'd1;
                    end
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_address = r_wr_addr;
    assign wr_index   = r_wr_idx;
    assign miss_count = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_sprite_index_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_index_writer
//  Description : Directed self-checking bench for sprite_index_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_index_writer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  x0 = '0;
    logic [9:0]  y0 = '0;
    logic [9:0]  spr_w = '0;
    logic [9:0]  spr_h = '0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = '0;
    logic [23:0] pal_color = '0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_ready;
    logic        wr_en;
    logic [18:0] wr_address;
    logic [3:0]  wr_index;
    logic        busy;
    logic        done;
    logic [15:0] miss_count;

    sprite_index_writer #(
        .FB_WIDTH  (640),
        .FB_HEIGHT (480),
        .ADDR_W    (19),
        .IDX_W     (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .spr_w      (spr_w),
        .spr_h      (spr_h),
        .pal_we     (pal_we),
        .pal_idx    (pal_idx),
        .pal_color  (pal_color),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_index   (wr_index),
        .busy       (busy),
        .done       (done),
        .miss_count (miss_count)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Write/done log, sampled on the falling edge.
    int wa[$];
    int wi[$];
    int wc[$];
    int dc[$];
    bit ready_seen;

    always @(negedge Clk) begin
        if (wr_en) begin
            wa.push_back(int'(wr_address));
            wi.push_back(int'(wr_index));
            wc.push_back(cyc);
        end
        if (done) dc.push_back(cyc);
        if (pix_ready) ready_seen = 1'b1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wi.delete();
        wc.delete();
        dc.delete();
        ready_seen = 1'b0;
    endtask

    task automatic pal_write(input int idx, input logic [23:0] c);
        pal_we    = 1'b1;
        pal_idx   = 4'(idx);
        pal_color = c;
        tick();
        pal_we    = 1'b0;
    endtask

    task automatic do_start(input int x, input int y, input int w, input int h, output int s);
        x0    = 10'(x);
        y0    = 10'(y);
        spr_w = 10'(w);
        spr_h = 10'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
        s     = cyc;
    endtask

    task automatic push_pixel(input logic [23:0] d);
        int b;
        pix_valid = 1'b1;
        pix_data  = d;
        b = 0;
        while (!pix_ready && b < 20) begin
            tick();
            b++;
        end
        if (!pix_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_pixel_timeout: pix_ready=%0b required=1", pix_ready);
        end
        tick();
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (dc.size() == 0 && b < 30) begin
            tick();
            b++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({pix_ready, wr_en, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {pix_ready, wr_en, busy, done});
        end
        n_tests++;
        if (wr_address !== 19'd0 || wr_index !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_wr_port: addr=%0d idx=%0d required 0/0", wr_address, wr_index);
        end
        n_tests++;
        if (miss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_miss: got %0d required 0", miss_count);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int s;
        int ea[4];
        int ei[4];
        ea = '{642, 643, 1282, 1283};
        ei = '{1, 2, 2, 1};
        pal_write(1, 24'hFF0000);
        pal_write(2, 24'h8A4BFE);
        clear_log();
        do_start(2, 1, 2, 2, s);
        n_tests++;
        if (busy !== 1'b1 || pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%0b ready=%0b required 1/1", busy, pix_ready);
        end
        push_pixel(24'hFF0000);
        push_pixel(24'h8A4BFE);
        push_pixel(24'h8A4BFE);
        push_pixel(24'hFF0000);
        pix_valid = 1'b0;
        wait_done();
        n_tests++;
        if (wa.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes required 4", wa.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (wa[i] != ea[i] || wi[i] != ei[i] || wc[i] != s + 1 + i) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: addr=%0d idx=%0d cyc=%0d required %0d/%0d/%0d",
                             i, wa[i], wi[i], wc[i], ea[i], ei[i], s + 1 + i);
                end
            end
        end
        n_tests++;
        if (dc.size() != 1 || dc[0] != s + 4) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d cyc=%0d required 1 at %0d",
                     dc.size(), (dc.size() > 0) ? dc[0] : -1, s + 4);
        end
        n_tests++;
        if (miss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL basic_miss: got %0d required 0", miss_count);
        end
    endtask

    task automatic test_stall();
        int s;
        int ea[4];
        int ec[4];
        ea = '{642, 643, 1282, 1283};
        clear_log();
        do_start(2, 1, 2, 2, s);
        ec = '{s + 1, s + 2, s + 6, s + 7};
        push_pixel(24'hFF0000);
        push_pixel(24'h8A4BFE);
        pix_valid = 1'b0;
        tick();
        tick();
        tick();
        push_pixel(24'h8A4BFE);
        push_pixel(24'hFF0000);
        pix_valid = 1'b0;
        wait_done();
        n_tests++;
        if (wa.size() != 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d writes required 4", wa.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (wa[i] != ea[i] || wc[i] != ec[i]) begin
                    n_fail++;
                    $display("FAIL stall_write%0d: addr=%0d cyc=%0d required %0d/%0d",
                             i, wa[i], wc[i], ea[i], ec[i]);
                end
            end
        end
        n_tests++;
        if (dc.size() != 1 || dc[0] != s + 7) begin
            n_fail++;
            $display("FAIL stall_done: pulses=%0d cyc=%0d required 1 at %0d",
                     dc.size(), (dc.size() > 0) ? dc[0] : -1, s + 7);
        end
    endtask

    task automatic test_lookup();
        int s;
        pal_write(3, 24'h00FF00);
        pal_write(5, 24'h00FF00);
        clear_log();
        do_start(0, 0, 2, 1, s);
        push_pixel(24'h00FF00);
        push_pixel(24'h123456);
        pix_valid = 1'b0;
        wait_done();
        n_tests++;
        if (wa.size() != 1 || wa[0] != 0 || wi[0] != 3) begin
            n_fail++;
            $display("FAIL lookup_lowest: writes=%0d addr=%0d idx=%0d required 1/0/3",
                     wa.size(), (wa.size() > 0) ? wa[0] : -1, (wi.size() > 0) ? wi[0] : -1);
        end
        n_tests++;
        if (miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL lookup_miss: got %0d required 1", miss_count);
        end
        n_tests++;
        if (dc.size() != 1 || dc[0] != s + 2) begin
            n_fail++;
            $display("FAIL lookup_done: pulses=%0d required 1 at %0d", dc.size(), s + 2);
        end
    endtask

    task automatic test_palette_timing();
        int s;
        clear_log();
        do_start(10, 0, 2, 1, s);
        // Palette write and lookup of the same colour in the same cycle.
        pal_we    = 1'b1;
        pal_idx   = 4'd6;
        pal_color = 24'hABCDEF;
        pix_valid = 1'b1;
        pix_data  = 24'hABCDEF;
        tick();
        pal_we = 1'b0;
        push_pixel(24'hABCDEF);
        pix_valid = 1'b0;
        wait_done();
        n_tests++;
        if (wa.size() != 1 || wa[0] != 11 || wi[0] != 6) begin
            n_fail++;
            $display("FAIL paltime_write: writes=%0d addr=%0d idx=%0d required 1/11/6",
                     wa.size(), (wa.size() > 0) ? wa[0] : -1, (wi.size() > 0) ? wi[0] : -1);
        end
        n_tests++;
        if (miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL paltime_miss: got %0d required 1", miss_count);
        end
    endtask

    task automatic test_clip();
        int s;
        clear_log();
        do_start(639, 479, 2, 2, s);
        for (int i = 0; i < 4; i++) push_pixel(24'hFF0000);
        pix_valid = 1'b0;
        wait_done();
        n_tests++;
        if (wa.size() != 1 || wa[0] != 307199 || wi[0] != 1) begin
            n_fail++;
            $display("FAIL clip_write: writes=%0d addr=%0d idx=%0d required 1/307199/1",
                     wa.size(), (wa.size() > 0) ? wa[0] : -1, (wi.size() > 0) ? wi[0] : -1);
        end
        n_tests++;
        if (dc.size() != 1 || dc[0] != s + 4) begin
            n_fail++;
            $display("FAIL clip_done: pulses=%0d required 1 at %0d", dc.size(), s + 4);
        end
        n_tests++;
        if (miss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clip_miss: got %0d required 0", miss_count);
        end
        n_tests++;
        if (wr_en !== 1'b0 || wr_address !== 19'd307199 || wr_index !== 4'd1) begin
            n_fail++;
            $display("FAIL clip_hold: en=%0b addr=%0d idx=%0d required 0/307199/1",
                     wr_en, wr_address, wr_index);
        end
    endtask

    task automatic test_zero_width();
        int s;
        clear_log();
        do_start(5, 5, 0, 3, s);
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (dc.size() != 1 || dc[0] != s) begin
            n_fail++;
            $display("FAIL zero_done: pulses=%0d cyc=%0d required 1 at %0d",
                     dc.size(), (dc.size() > 0) ? dc[0] : -1, s);
        end
        n_tests++;
        if (ready_seen !== 1'b0 || wa.size() != 0) begin
            n_fail++;
            $display("FAIL zero_quiet: ready_seen=%0b writes=%0d required 0/0", ready_seen, wa.size());
        end
    endtask

    task automatic test_reset_mid();
        int s;
        clear_log();
        do_start(0, 0, 2, 2, s);
        push_pixel(24'hFF0000);
        pix_valid = 1'b1;
        pix_data  = 24'h8A4BFE;
        Reset     = 1'b1;
        tick();
        n_tests++;
        if ({busy, wr_en, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_flags: busy/wr_en/done=%b required 000", {busy, wr_en, done});
        end
        Reset     = 1'b0;
        pix_valid = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if (dc.size() != 0 || wa.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_drop: done=%0d writes=%0d required 0/1", dc.size(), wa.size());
        end
        // Fresh rectangle: the palette was cleared, so black maps to index 0.
        clear_log();
        do_start(5, 0, 2, 1, s);
        n_tests++;
        if (miss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL fresh_miss_start: got %0d required 0", miss_count);
        end
        push_pixel(24'h000000);
        push_pixel(24'hFF0000);
        pix_valid = 1'b0;
        wait_done();
        n_tests++;
        if (wa.size() != 1 || wa[0] != 5 || wi[0] != 0) begin
            n_fail++;
            $display("FAIL fresh_write: writes=%0d addr=%0d idx=%0d required 1/5/0",
                     wa.size(), (wa.size() > 0) ? wa[0] : -1, (wi.size() > 0) ? wi[0] : -1);
        end
        n_tests++;
        if (miss_count !== 16'd1 || dc.size() != 1) begin
            n_fail++;
            $display("FAIL fresh_end: miss=%0d done=%0d required 1/1", miss_count, dc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_lookup();
        test_palette_timing();
        test_clip();
        test_zero_width();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
